// File: rtl/measure_window_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : measure_window_sequencer_if
//  Description : Control / result-handshake bundle between the user controls
//                and consumer logic (master side) and the measurement window
//                sequencer (slave side).
//  Revision    : 1.0  initial release
// ============================================================================
interface measure_window_sequencer_if;
  logic run;           // level: repeat windows back-to-back while high
  logic single;        // one-cycle pulse: start one window from IDLE
  logic result_ack;    // consumer has taken the latched result
  logic gate_out;      // counter enable
  logic clear_out;     // one-cycle counter clear before each gate
  logic load_out;      // one-cycle latch strobe after each gate
  logic busy;          // sequencer is inside a window
  logic result_valid;  // latched result waiting for ack
  logic overrun;       // sticky: a result was overwritten before ack

  modport master (
    output run, single, result_ack,
    input  gate_out, clear_out, load_out, busy, result_valid, overrun
  );

  modport slave (
    input  run, single, result_ack,
    output gate_out, clear_out, load_out, busy, result_valid, overrun
  );
endinterface
`default_nettype wire

// File: rtl/measure_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : measure_window_sequencer
//  Description : Sequences a gated event counter through measurement windows
//                (clear -> gate -> load -> hold-off) in run or single-shot
//                mode, with a valid/ack result handshake and sticky overrun.
//  Revision    : 1.0  initial release
// ============================================================================
module measure_window_sequencer #(
  parameter int unsigned      CNT_W          = 22,
  parameter logic [CNT_W-1:0] GATE_CYCLES    = 22'd2_000_000,
  parameter logic [CNT_W-1:0] HOLDOFF_CYCLES = 22'd2
) (
  input  logic                      clk,
  input  logic                      reset,
  measure_window_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Terminal counts; the counter stops at these so it can never wrap.
  localparam logic [CNT_W-1:0] c_gate_last = GATE_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_hold_last = HOLDOFF_CYCLES - CNT_W'(1);
  localparam bit               c_has_hold  = (HOLDOFF_CYCLES != '0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gate;
  logic             r_clear;
  logic             r_load;
  logic             r_busy;
  logic             r_valid;
  logic             r_overrun;

  // Window FSM with every output registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gate    <= 1'b0;
      r_clear   <= 1'b0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_load  <= 1'b0;

      // Ack clears a pending result; a load in this same cycle overrides it.
      if (bus.result_ack && r_valid) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.run || bus.single) begin
            r_state <= ST_CLEAR;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ST_CLEAR: begin
          r_cnt   <= '0;
          r_state <= ST_GATE;
          r_gate  <= 1'b1;
        end

        ST_GATE: begin
          if (r_cnt == c_gate_last) begin
            r_state <= ST_LOAD;
            r_gate  <= 1'b0;
            r_load  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_LOAD: begin
          r_valid <= 1'b1;
          if (r_valid && !bus.result_ack) begin
            r_overrun <= 1'b1;
          end
          if (c_has_hold) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end else if (bus.run) begin
            r_state <= ST_CLEAR;
            r_clear <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (r_cnt == c_hold_last) begin
            if (bus.run) begin
              r_state <= ST_CLEAR;
              r_clear <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_gate  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_out     = r_gate;
  assign bus.clear_out    = r_clear;
  assign bus.load_out     = r_load;
  assign bus.busy         = r_busy;
  assign bus.result_valid = r_valid;
  assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_measure_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_measure_window_sequencer
//  Description : Scoreboard bench for measure_window_sequencer. Two instances
//                (hold-off 2 and hold-off 0) share one stimulus stream; a
//                timeline model predicts every output for every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_measure_window_sequencer;

  localparam int G_A = 5;
  localparam int H_A = 2;
  localparam int G_B = 5;
  localparam int H_B = 0;

  typedef struct {
    int         cyc;
    logic [5:0] v;   // {gate, clear, load, busy, valid, overrun}
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  measure_window_sequencer_if bus_a ();
  measure_window_sequencer_if bus_b ();

  measure_window_sequencer #(
    .CNT_W(22), .GATE_CYCLES(22'(G_A)), .HOLDOFF_CYCLES(22'(H_A))
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  measure_window_sequencer #(
    .CNT_W(22), .GATE_CYCLES(22'(G_B)), .HOLDOFF_CYCLES(22'(H_B))
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Stimulus as currently applied
  bit s_rst, s_run, s_single, s_ack;

  // Timeline model: a window started in cycle m_s has clear at +0,
  // gate at +1..+G, load at +G+1, and lasts G+H+2 cycles in total.
  bit m_act [2];
  int m_s   [2];
  bit m_val [2];
  bit m_ovr [2];
  int m_g   [2];
  int m_h   [2];
  int cyc;

  exp_t q_a [$];
  exp_t q_b [$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [5:0] model_out(int i, int k);
    int p;
    bit g, c, l;
    p = k - m_s[i];
    c = m_act[i] && (p == 0);
    g = m_act[i] && (p >= 1) && (p <= m_g[i]);
    l = m_act[i] && (p == m_g[i] + 1);
    return {g, c, l, m_act[i], m_val[i], m_ovr[i]};
  endfunction

  // Advance instance i across the edge that ends cycle k.
  function automatic void model_step(int i, int k);
    int p, len;
    bit ld;
    p   = k - m_s[i];
    len = m_g[i] + m_h[i] + 2;
    ld  = m_act[i] && (p == m_g[i] + 1);
    if (s_rst) begin
      m_act[i] = 1'b0;
      m_val[i] = 1'b0;
      m_ovr[i] = 1'b0;
    end else begin
      if (ld) begin
        if (m_val[i] && !s_ack) m_ovr[i] = 1'b1;
        m_val[i] = 1'b1;
      end else if (s_ack && m_val[i]) begin
        m_val[i] = 1'b0;
      end
      if (!m_act[i]) begin
        if (s_run || s_single) begin
          m_act[i] = 1'b1;
          m_s[i]   = k + 1;
        end
      end else if (p == len - 1) begin
        if (s_run) m_s[i] = k + 1;
        else       m_act[i] = 1'b0;
      end
    end
  endfunction

  // Apply one cycle of inputs, then predict the outputs of the next cycle.
  task automatic drive(bit r, bit rn, bit sg, bit ak);
    s_rst = r; s_run = rn; s_single = sg; s_ack = ak;
    reset = r;
    bus_a.run = rn; bus_a.single = sg; bus_a.result_ack = ak;
    bus_b.run = rn; bus_b.single = sg; bus_b.result_ack = ak;
    @(posedge clk);
    model_step(0, cyc);
    model_step(1, cyc);
    cyc++;
    q_a.push_back('{cyc, model_out(0, cyc)});
    q_b.push_back('{cyc, model_out(1, cyc)});
    #1;
  endtask

  task automatic check(string name, exp_t e, logic [5:0] got);
    n_cmp++;
    if (got !== e.v) begin
      n_bad++;
      $display("FAIL %s cycle=%0d {gate,clear,load,busy,valid,overrun} got=%b expected=%b",
               name, e.cyc, got, e.v);
    end
  endtask

  // Monitor: compare whatever the DUTs present against queued predictions.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("hold2", e, {bus_a.gate_out, bus_a.clear_out, bus_a.load_out,
                         bus_a.busy, bus_a.result_valid, bus_a.overrun});
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("hold0", e, {bus_b.gate_out, bus_b.clear_out, bus_b.load_out,
                         bus_b.busy, bus_b.result_valid, bus_b.overrun});
    end
  end

  initial begin
    bit rn;
    m_g[0] = G_A; m_h[0] = H_A;
    m_g[1] = G_B; m_h[1] = H_B;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_s[i] = 0; m_val[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    cyc = 0;

    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);

    // Single-shot window, then idle
    drive(0, 0, 1, 0);
    repeat (14) drive(0, 0, 0, 0);

    // Second single pulse during GATE must be ignored
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    repeat (12) drive(0, 0, 0, 0);

    // Continuous run, every result acknowledged
    repeat (40) drive(0, 1, 0, 1);
    repeat (12) drive(0, 0, 0, 0);

    // Continuous run, never acknowledged -> overrun, sticky past a late ack
    repeat (40) drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    repeat (12) drive(0, 0, 0, 0);

    // Reset mid-gate aborts the window; a fresh single restarts cleanly
    drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    repeat (12) drive(0, 0, 0, 0);

    // Randomized traffic: run toggles occasionally, sporadic single/ack/reset
    rn = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 99) < 6) rn = ~rn;
      drive($urandom_range(0, 199) < 2, rn,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30);
    end
    repeat (20) drive(0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
